// File: rtl/me_result_if.sv
// Handshake bundle between the result writer, the ME core (input side) and the
// frame result memory (write side).
interface me_result_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_mv_x;
    logic [6:0]  in_mv_y;
    logic [23:0] in_sad;
    logic        wr_valid;
    logic        wr_ready;
    logic [21:0] wr_addr;
    logic [33:0] wr_data;

    // master: the environment (ME core + memory); slave: the result writer
    modport master (
        output in_valid, in_mv_x, in_mv_y, in_sad, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_mv_x, in_mv_y, in_sad, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/me_result_writer.sv
// Motion-estimation result sink: packs MV/SAD results into 34-bit words and
// writes one frame of them sequentially to the result memory via a small FIFO.
module me_result_writer #(
    parameter int unsigned FRAME_WORDS = 8160,
    parameter logic [21:0] BASE_ADDR   = 22'd0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    me_result_if.slave  rif,
    output logic        busy,
    output logic        done
);

    localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [21:0] FW   = 22'(FRAME_WORDS);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e          state_q, state_d;
    logic [21:0]     acc_cnt_q, acc_cnt_d;
    logic [21:0]     wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [AW:0]     fill_q;
    logic [33:0]     mem_q [FIFO_DEPTH];
    logic            fifo_empty, fifo_full;
    logic            push, pop;
    logic [19:0]     sad20;
    logic [33:0]     packed_word;

    assign fifo_empty = (fill_q == '0);
    assign fifo_full  = (fill_q == FULL);

    // SAD is saturated to 20 bits rather than truncated
    assign sad20       = (rif.in_sad > 24'h0FFFFF) ? 20'hFFFFF : rif.in_sad[19:0];
    assign packed_word = {rif.in_mv_x, rif.in_mv_y, sad20};

    // All outputs decode from registered state only
    assign rif.in_ready = (state_q == StRun) && !fifo_full && (acc_cnt_q < FW);
    assign rif.wr_valid = ((state_q == StRun) || (state_q == StFlush)) && !fifo_empty;
    assign rif.wr_data  = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign rif.wr_addr  = BASE_ADDR + wr_cnt_q;
    assign busy         = (state_q == StRun) || (state_q == StFlush);
    assign done         = (state_q == StDone);

    assign push = rif.in_valid && rif.in_ready;
    assign pop  = rif.wr_valid && rif.wr_ready;

    always_comb begin
        state_d   = state_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        unique case (state_q)
            StIdle: begin
                acc_cnt_d = '0;
                wr_cnt_d  = '0;
                if (start) state_d = StRun;
            end
            StRun: begin
                if (push) begin
                    acc_cnt_d = acc_cnt_q + 22'd1;
                    if (acc_cnt_q + 22'd1 == FW) state_d = StFlush;
                end
                if (pop) wr_cnt_d = wr_cnt_q + 22'd1;
            end
            StFlush: begin
                if (pop) begin
                    wr_cnt_d = wr_cnt_q + 22'd1;
                    if (wr_cnt_q + 22'd1 == FW) state_d = StDone;
                end
            end
            StDone: begin
                // Clear here so wr_addr reads BASE_ADDR from the first idle cycle
                acc_cnt_d = '0;
                wr_cnt_d  = '0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end

    // Storage needs no reset: wr_data is gated to zero while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= packed_word;
    end

endmodule

// File: tb/tb_me_result_writer.sv
// Bench for me_result_writer: two instances (base 0 and base 3FFFFE) share one
// stimulus stream and are checked every cycle against a queue-based model.
module tb_me_result_writer;

    localparam int unsigned FW     = 4;
    localparam int unsigned DEPTH  = 4;
    localparam logic [21:0] BASE_B = 22'h3FFFFE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [6:0] mv_x = '0;
    logic [6:0] mv_y = '0;
    logic [23:0] sad = '0;
    logic wr_ready = 1'b0;
    logic busy_a, done_a, busy_b, done_b;

    always #5 clk = ~clk;

    me_result_if ia ();
    me_result_if ib ();

    assign ia.in_valid = in_valid;
    assign ia.in_mv_x  = mv_x;
    assign ia.in_mv_y  = mv_y;
    assign ia.in_sad   = sad;
    assign ia.wr_ready = wr_ready;
    assign ib.in_valid = in_valid;
    assign ib.in_mv_x  = mv_x;
    assign ib.in_mv_y  = mv_y;
    assign ib.in_sad   = sad;
    assign ib.wr_ready = wr_ready;

    me_result_writer #(.FRAME_WORDS(FW), .BASE_ADDR(22'd0), .FIFO_DEPTH(DEPTH)) u_a (
        .clk(clk), .rst(rst), .start(start), .rif(ia), .busy(busy_a), .done(done_a)
    );
    me_result_writer #(.FRAME_WORDS(FW), .BASE_ADDR(BASE_B), .FIFO_DEPTH(DEPTH)) u_b (
        .clk(clk), .rst(rst), .start(start), .rif(ib), .busy(busy_b), .done(done_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [33:0] pack(input logic [6:0] x, input logic [6:0] y,
                                         input logic [23:0] s);
        logic [19:0] s20;
        s20 = (s > 24'h0FFFFF) ? 20'hFFFFF : s[19:0];
        return {x, y, s20};
    endfunction

    // Behavioural model: a frame is "active" until FW words have left the queue
    bit          m_active = 0;
    bit          m_done = 0;
    int          m_acc = 0;
    int          m_wr = 0;
    int          m_dones = 0;
    logic [33:0] m_q[$];

    function automatic bit e_in_ready();
        return m_active && (m_acc < FW) && (m_q.size() < DEPTH);
    endfunction
    function automatic bit e_wr_valid();
        return m_active && (m_q.size() > 0);
    endfunction
    function automatic logic [33:0] e_wr_data();
        return (m_q.size() > 0) ? m_q[0] : 34'd0;
    endfunction

    always @(posedge clk) begin
        bit p_in;
        bit p_out;
        if (rst) begin
            m_active = 0; m_done = 0; m_acc = 0; m_wr = 0;
            m_q.delete();
        end else begin
            p_in  = in_valid && e_in_ready();
            p_out = e_wr_valid() && wr_ready;
            if (m_done) begin
                m_done = 0; m_acc = 0; m_wr = 0;
            end else if (!m_active) begin
                if (start) m_active = 1;
            end else begin
                if (p_out) begin
                    void'(m_q.pop_front());
                    m_wr++;
                end
                if (p_in) begin
                    m_q.push_back(pack(mv_x, mv_y, sad));
                    m_acc++;
                end
                if (m_wr == FW) begin
                    m_active = 0;
                    m_done   = 1;
                    m_dones++;
                end
            end
        end
    end

    // Per-cycle compare plus observation logs used by the literal checks
    bit          chk_en = 0;
    logic [21:0] log_addr_a[$];
    logic [21:0] log_addr_b[$];
    logic [33:0] log_data_a[$];
    int          acc_obs = 0;
    int          obs_dones = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready_a", ia.in_ready, e_in_ready());
            chk("wr_valid_a", ia.wr_valid, e_wr_valid());
            chk("wr_data_a",  ia.wr_data,  e_wr_data());
            chk("wr_addr_a",  ia.wr_addr,  22'(m_wr));
            chk("busy_a",     busy_a,      m_active);
            chk("done_a",     done_a,      m_done);
            chk("in_ready_b", ib.in_ready, e_in_ready());
            chk("wr_valid_b", ib.wr_valid, e_wr_valid());
            chk("wr_data_b",  ib.wr_data,  e_wr_data());
            chk("wr_addr_b",  ib.wr_addr,  22'(BASE_B + 22'(m_wr)));
            chk("busy_b",     busy_b,      m_active);
            chk("done_b",     done_b,      m_done);
            if (ia.wr_valid && wr_ready) begin
                log_addr_a.push_back(ia.wr_addr);
                log_data_a.push_back(ia.wr_data);
            end
            if (ib.wr_valid && wr_ready) log_addr_b.push_back(ib.wr_addr);
            if (ia.in_valid && ia.in_ready) acc_obs++;
            if (done_a) obs_dones++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_addr_a.delete();
        log_addr_b.delete();
        log_data_a.delete();
        acc_obs = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        while ((m_active || m_done) && n < budget) begin
            tick();
            n++;
        end
        chk("frame_timeout", 64'(n >= budget), 64'd0);
    endtask

    task automatic send(input logic [6:0] x, input logic [6:0] y, input logic [23:0] s);
        int n = 0;
        in_valid = 1'b1; mv_x = x; mv_y = y; sad = s;
        while (!ia.in_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_timeout", 64'(n >= 50), 64'd0);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int d0;
        int n;
        repeat (3) tick();
        chk_en = 1;
        chk("rst_addr_a", ia.wr_addr, 22'd0);
        chk("rst_addr_b", ib.wr_addr, 22'h3FFFFE);
        chk("rst_data_a", ia.wr_data, 34'd0);
        chk("rst_ready_a", ia.in_ready, 1'b0);
        rst = 1'b0;
        tick();

        // Basic frame
        clear_logs();
        wr_ready = 1'b1;
        pulse_start();
        chk("start_ready", ia.in_ready, 1'b1);
        chk("start_busy", busy_a, 1'b1);
        in_valid = 1'b1; mv_x = 7'h01; mv_y = 7'h7F; sad = 24'd16;
        repeat (4) tick();
        in_valid = 1'b0;
        wait_frame(50);
        chk("basic_nwr", log_addr_a.size(), 4);
        for (int i = 0; i < 4 && i < log_addr_a.size(); i++) begin
            chk("basic_addr", log_addr_a[i], 22'(i));
            chk("basic_data", log_data_a[i], 34'h00FF00010);
        end
        chk("wrap_n", log_addr_b.size(), 4);
        if (log_addr_b.size() == 4) begin
            chk("wrap_addr0", log_addr_b[0], 22'h3FFFFE);
            chk("wrap_addr1", log_addr_b[1], 22'h3FFFFF);
            chk("wrap_addr2", log_addr_b[2], 22'h000000);
            chk("wrap_addr3", log_addr_b[3], 22'h000001);
        end
        chk("basic_dones", obs_dones, 1);
        tick();

        // SAD saturation
        clear_logs();
        pulse_start();
        send(7'h00, 7'h00, 24'h123456);
        send(7'h00, 7'h00, 24'h0FFFFF);
        send(7'h00, 7'h00, 24'h000000);
        send(7'h40, 7'h3F, 24'hFFFFFF);
        wait_frame(50);
        chk("sat_nwr", log_data_a.size(), 4);
        if (log_data_a.size() == 4) begin
            chk("sat_big", log_data_a[0], 34'h0000FFFFF);
            chk("sat_edge", log_data_a[1], 34'h0000FFFFF);
            chk("sat_zero", log_data_a[2], 34'h000000000);
            chk("sat_mv", log_data_a[3], 34'h203FFFFFF);
        end
        tick();

        // Backpressure: memory stalled while the core keeps offering
        clear_logs();
        wr_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; mv_x = 7'(i + 1); mv_y = 7'h00; sad = 24'(i);
            tick();
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc_obs, 4);
        chk("bp_ready", ia.in_ready, 1'b0);
        chk("bp_addr", ia.wr_addr, 22'd0);
        chk("bp_data", ia.wr_data, 34'h008000000);
        wr_ready = 1'b1;
        wait_frame(50);
        chk("bp_nwr", log_data_a.size(), 4);
        for (int i = 0; i < 4 && i < log_data_a.size(); i++)
            chk("bp_order", log_data_a[i], {7'(i + 1), 7'h00, 20'(i)});
        tick();

        // Frame limit: more results offered than the frame holds
        clear_logs();
        d0 = obs_dones;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; mv_x = 7'(i); mv_y = 7'(i); sad = 24'(100 + i);
            tick();
        end
        in_valid = 1'b0;
        wait_frame(50);
        chk("lim_accepted", acc_obs, 4);
        chk("lim_nwr", log_addr_a.size(), 4);
        chk("lim_dones", obs_dones - d0, 1);
        tick();

        // Reset mid-frame
        clear_logs();
        d0 = obs_dones;
        pulse_start();
        in_valid = 1'b1; mv_x = 7'h05; mv_y = 7'h06; sad = 24'h777;
        n = 0;
        while (log_addr_a.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", ia.wr_valid, 1'b0);
        chk("mid_rst_busy", busy_a, 1'b0);
        chk("mid_rst_addr", ia.wr_addr, 22'd0);
        chk("mid_rst_nodone", obs_dones - d0, 0);
        clear_logs();
        pulse_start();
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        wait_frame(50);
        chk("post_rst_nwr", log_addr_a.size(), 4);
        if (log_addr_a.size() > 0) chk("post_rst_addr0", log_addr_a[0], 22'd0);
        chk("post_rst_dones", obs_dones - d0, 1);

        // Randomised frames
        for (int f = 0; f < 30; f++) begin
            start = 1'b1;
            in_valid = ($urandom_range(3) != 0);
            tick();
            start = 1'b0;
            n = 0;
            while ((m_active || m_done) && n < 400) begin
                in_valid = ($urandom_range(3) != 0);
                mv_x = 7'($urandom);
                mv_y = 7'($urandom);
                sad = ($urandom_range(1) != 0) ? 24'($urandom) : 24'($urandom_range(20'hFFFFF));
                wr_ready = ($urandom_range(2) != 0);
                start = ($urandom_range(9) == 0);
                rst = ($urandom_range(299) == 0);
                tick();
                n++;
            end
            chk("rand_timeout", 64'(n >= 400), 64'd0);
            rst = 1'b0; start = 1'b0; in_valid = 1'b0;
            repeat ($urandom_range(3)) tick();
        end
        tick();
        chk("done_count", obs_dones, m_dones);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
